rotate_req_queue: RTL

Buffered request front-end for the combinational `rotate_left_rfactor_times` datapath.
- Accepts rotate requests (word + rotate factor) over a valid/ready handshake and queues them in a DEPTH-entry FIFO.
- Drives the FIFO head onto the rotator's `data_in`/`rfactor` and captures the rotator's `data_out` into a registered response port with its own valid/ready handshake.
- Sits directly upstream of the rotator, which feeds its result straight back to this block; together they form a pipelined rotate unit.

---
 rtl/rotate_pkg.sv | 14 +
 rtl/rot_req_fifo.sv | 69 ++++++
 rtl/rotate_req_queue.sv | 96 +++++++++
 3 files changed

// File: rtl/rotate_pkg.sv
// Shared types and constants for the rotate request queue.
// The optional request counter is enabled by defining ROT_REQ_STATS_EN.
package rotate_pkg;

    localparam int ROT_N          = 8;
    localparam int ROT_RF_W       = $clog2(ROT_N);
    localparam int ROT_FIFO_DEPTH = 4;

    typedef struct packed {
        logic [ROT_N-1:0]    data;
        logic [ROT_RF_W-1:0] rfactor;
    } rot_req_t;

endpackage

// File: rtl/rot_req_fifo.sv
// Request FIFO: storage, wrapping pointers and an occupancy count that
// yields full/empty. The head reads as zero while the FIFO is empty.
module rot_req_fifo
    import rotate_pkg::*;
#(
    parameter int W     = ROT_N + ROT_RF_W,
    parameter int DEPTH = ROT_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // NOTE: every output gets a default first, so no path leaves a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them
    // update together at the edge regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; count/pointers alone decide what is valid,
    // and the empty-head mux hides stale words.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/rotate_req_queue.sv
// Buffered front-end for the combinational rotator: request FIFO plus a
// registered response port. Define ROT_REQ_STATS_EN to add req_count.
module rotate_req_queue
    import rotate_pkg::*;
#(
    parameter int N     = ROT_N,
    parameter int DEPTH = ROT_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [N-1:0]         req_data,
    input  logic [$clog2(N)-1:0] req_rfactor,
    output logic [N-1:0]         rot_data_in,
    output logic [$clog2(N)-1:0] rot_rfactor,
    input  logic [N-1:0]         rot_data_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [N-1:0]         rsp_data
`ifdef ROT_REQ_STATS_EN
    ,
    output logic [15:0]          req_count
`endif
);

    localparam int RF_W = $clog2(N);
    localparam int W    = N + RF_W;

    logic         fifo_full, fifo_empty;
    logic         push, load;
    logic [W-1:0] head;
    logic         rsp_valid_q, rsp_valid_d;
    logic [N-1:0] rsp_data_q, rsp_data_d;

    rot_req_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (load),
        .wdata_i ({req_data, req_rfactor}),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign req_ready   = !fifo_full;
    assign push        = req_valid && !fifo_full;
    assign rot_data_in = head[W-1:RF_W];
    assign rot_rfactor = head[RF_W-1:0];

    // The head moves into the response register whenever that slot is free
    // or being emptied this cycle; the rotator result is captured directly.
    assign load = !fifo_empty && (!rsp_valid_q || rsp_ready);

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        if (load) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rot_data_out;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

`ifdef ROT_REQ_STATS_EN
    logic [15:0] req_count_q, req_count_d;

    assign req_count_d = push ? req_count_q + 16'd1 : req_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) req_count_q <= '0;
        else     req_count_q <= req_count_d;
    end

    assign req_count = req_count_q;
`endif

endmodule
